// File: rtl/refresh_scheduler.sv
// ----------------------------------------------------------------------------
// refresh_scheduler
//   Collects refresh ticks from the refresh counter and sequences them onto
//   the DRAM command path. For each grant it issues PRECHARGE ALL, waits
//   T_RP, then issues AUTO REFRESH. After each refresh it waits T_RFC. If
//   more refreshes are owed and the grant is still held, it chains further
//   AUTO REFRESH commands without another precharge.
//
// Parameters
//   T_RP      precharge-to-refresh spacing in clk cycles (>= 1)
//   T_RFC     refresh-to-next-command spacing in clk cycles (>= 1)
//   MAX_PEND  maximum postponed refreshes held (1..15)
//   URGENT_TH pend_cnt level at which urgent asserts (1..MAX_PEND)
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset (release synchronised outside)
//   ref_int      single-cycle refresh tick
//   ref_ack      command-path grant from the main controller
//   ref_req      request for the command path (any state but IDLE)
//   cmd_pre_all  one-cycle PRECHARGE ALL strobe
//   cmd_auto_ref one-cycle AUTO REFRESH strobe
//   ref_busy     scheduler not IDLE
//   pend_cnt     refreshes owed
//   urgent       pend_cnt >= URGENT_TH
//   ref_overflow sticky: a tick arrived with the pending count full
// ----------------------------------------------------------------------------
module refresh_scheduler #(
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_RFC     = 9,
    parameter int unsigned MAX_PEND  = 8,
    parameter int unsigned URGENT_TH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ref_int,
    input  logic       ref_ack,
    output logic       ref_req,
    output logic       cmd_pre_all,
    output logic       cmd_auto_ref,
    output logic       ref_busy,
    output logic [3:0] pend_cnt,
    output logic       urgent,
    output logic       ref_overflow
);

    localparam int unsigned   T_MAX    = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned   CW       = $clog2(T_MAX) + 1;
    // Each wait state covers the spacing minus the strobe cycle itself.
    localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RFC_LOAD = CW'(T_RFC - 1);
    localparam logic [3:0]    PEND_MAX = 4'(MAX_PEND);
    localparam logic [3:0]    PEND_URG = 4'(URGENT_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PRECH,
        S_WAIT_RP,
        S_AREF,
        S_WAIT_RFC
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    pend_nxt;
    logic          overflow_set;
    logic          aref_now;
    logic          wait_done;
    logic          more_ref;

    assign aref_now  = (state == S_AREF);
    assign wait_done = (wait_cnt <= CW'(1));

    // Pending-count update. A tick and a refresh in the same cycle cancel.
    // A tick that arrives with the count full is dropped and flagged.
    always_comb begin
        pend_nxt     = pend_cnt;
        overflow_set = 1'b0;
        if (ref_int && !aref_now) begin
            if (pend_cnt == PEND_MAX)
                overflow_set = 1'b1;
            else
                pend_nxt = pend_cnt + 4'd1;
        end else if (!ref_int && aref_now && (pend_cnt != 4'd0)) begin
            pend_nxt = pend_cnt - 4'd1;
        end
    end

    // Chaining decision uses the post-update count. This way a refresh
    // issued this cycle is already deducted, and the T_RFC=1 path can
    // never issue a refresh with nothing owed.
    assign more_ref = (pend_nxt != 4'd0) && ref_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_cnt     <= 4'd0;
            ref_overflow <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (overflow_set)
                ref_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend_cnt != 4'd0)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (ref_ack)
                        state <= S_PRECH;
                end
                S_PRECH: begin
                    if (T_RP == 1) begin
                        state <= S_AREF;
                    end else begin
                        state    <= S_WAIT_RP;
                        wait_cnt <= RP_LOAD;
                    end
                end
                S_WAIT_RP: begin
                    if (wait_done) begin
                        state    <= S_AREF;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_AREF: begin
                    if (T_RFC == 1) begin
                        state <= more_ref ? S_AREF : S_IDLE;
                    end else begin
                        state    <= S_WAIT_RFC;
                        wait_cnt <= RFC_LOAD;
                    end
                end
                S_WAIT_RFC: begin
                    if (wait_done) begin
                        state    <= more_ref ? S_AREF : S_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // All outputs are decodes of registered state, so reset clears them at once.
    assign ref_req      = (state != S_IDLE);
    assign ref_busy     = (state != S_IDLE);
    assign cmd_pre_all  = (state == S_PRECH);
    assign cmd_auto_ref = aref_now;
    assign urgent       = (pend_cnt >= PEND_URG);

endmodule

// File: tb/tb_refresh_scheduler.sv
// ----------------------------------------------------------------------------
// tb_refresh_scheduler
//   Directed bench for refresh_scheduler. dut uses default timing. dut_c
//   uses T_RP=1 and T_RFC=1 to cover the zero-wait corners. Inputs change
//   and outputs are sampled on the falling edge. Cycle numbers in comments
//   count falling edges from the step that starts each scenario.
// ----------------------------------------------------------------------------
module tb_refresh_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ref_int, ref_ack;
    logic       ref_req, cmd_pre_all, cmd_auto_ref, ref_busy, urgent, ref_overflow;
    logic [3:0] pend_cnt;

    logic       ref_int_c, ref_ack_c;
    logic       ref_req_c, cmd_pre_all_c, cmd_auto_ref_c, ref_busy_c, urgent_c, ref_overflow_c;
    logic [3:0] pend_cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    refresh_scheduler dut (
        .clk(clk), .reset(reset), .ref_int(ref_int), .ref_ack(ref_ack),
        .ref_req(ref_req), .cmd_pre_all(cmd_pre_all), .cmd_auto_ref(cmd_auto_ref),
        .ref_busy(ref_busy), .pend_cnt(pend_cnt), .urgent(urgent),
        .ref_overflow(ref_overflow)
    );

    refresh_scheduler #(.T_RP(1), .T_RFC(1)) dut_c (
        .clk(clk), .reset(reset), .ref_int(ref_int_c), .ref_ack(ref_ack_c),
        .ref_req(ref_req_c), .cmd_pre_all(cmd_pre_all_c), .cmd_auto_ref(cmd_auto_ref_c),
        .ref_busy(ref_busy_c), .pend_cnt(pend_cnt_c), .urgent(urgent_c),
        .ref_overflow(ref_overflow_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Runs until the scheduler goes idle. Counts AUTO REFRESH strobes and
    // gives up after a fixed cycle budget.
    task automatic drain(output int n_aref, output logic done);
        n_aref = 0;
        done   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            cyc();
            if (cmd_auto_ref) n_aref++;
            if (!ref_req) done = 1'b1;
        end
    endtask

    initial begin
        int    exp_pend;
        int    n_aref;
        int    n_pre;
        logic  done;
        logic  aref_seen;
        logic  a;

        reset = 1'b0; ref_int = 1'b0; ref_ack = 1'b0;
        ref_int_c = 1'b0; ref_ack_c = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc();
        check("rst_ref_req",   ref_req,      0);
        check("rst_pre",       cmd_pre_all,  0);
        check("rst_aref",      cmd_auto_ref, 0);
        check("rst_busy",      ref_busy,     0);
        check("rst_pend",      pend_cnt,     0);
        check("rst_urgent",    urgent,       0);
        check("rst_overflow",  ref_overflow, 0);
        check("rst_c_ref_req", ref_req_c,    0);
        reset = 1'b1;
        cyc();
        check("post_rst_idle", ref_req, 0);

        // ---------------- single tick, grant tied high ----------------
        ref_ack = 1'b1;
        cyc(); ref_int = 1'b1;                      // cycle 0
        for (int c = 1; c <= 16; c++) begin
            cyc(); ref_int = 1'b0;
            check($sformatf("s1_pre_c%0d", c),  cmd_pre_all,  32'(c == 3));
            check($sformatf("s1_aref_c%0d", c), cmd_auto_ref, 32'(c == 6));
            check($sformatf("s1_req_c%0d", c),  ref_req,      32'(c >= 2 && c <= 14));
            check($sformatf("s1_busy_c%0d", c), ref_busy,     32'(c >= 2 && c <= 14));
            check($sformatf("s1_pend_c%0d", c), pend_cnt,     32'(c >= 1 && c <= 6));
        end

        // ---------------- grant withheld, 5 ticks ----------------
        ref_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); ref_int = 1'b1;
        end
        cyc(); ref_int = 1'b0;
        check("s2_pend5",   pend_cnt, 5);
        check("s2_urgent",  urgent,   1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("s2_hold_req%0d", i), ref_req,     1);
            check($sformatf("s2_hold_pre%0d", i), cmd_pre_all, 0);
        end
        ref_ack  = 1'b1;                            // cycle A
        exp_pend = 5;
        n_aref   = 0;
        n_pre    = 0;
        for (int k = 1; k <= 49; k++) begin
            cyc();
            // A brief grant drop in WAIT_RP must not disturb the sequence.
            if (k == 2) ref_ack = 1'b0;
            if (k == 3) ref_ack = 1'b1;
            a = (k >= 4) && (k <= 40) && (((k - 4) % 9) == 0);
            check($sformatf("s2_pre_k%0d", k),  cmd_pre_all,  32'(k == 1));
            check($sformatf("s2_aref_k%0d", k), cmd_auto_ref, 32'(a));
            check($sformatf("s2_pend_k%0d", k), pend_cnt,     32'(exp_pend));
            check($sformatf("s2_urg_k%0d", k),  urgent,       32'(exp_pend >= 4));
            check($sformatf("s2_req_k%0d", k),  ref_req,      32'(k <= 48));
            if (cmd_auto_ref) n_aref++;
            if (cmd_pre_all)  n_pre++;
            if (a) exp_pend--;
        end
        check("s2_n_aref",   n_aref,   5);
        check("s2_n_pre",    n_pre,    1);
        check("s2_pend_end", pend_cnt, 0);
        check("s2_urg_end",  urgent,   0);

        // ---------------- overflow ----------------
        ref_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(); ref_int = 1'b1;
        end
        cyc();                                      // ninth tick this cycle
        check("s3_pend8",      pend_cnt,     8);
        check("s3_ovf_before", ref_overflow, 0);
        cyc(); ref_int = 1'b0;
        check("s3_pend_hold",  pend_cnt,     8);
        check("s3_ovf_set",    ref_overflow, 1);
        ref_ack = 1'b1;
        drain(n_aref, done);
        check("s3_drain_done", done,         1);
        check("s3_n_aref",     n_aref,       8);
        check("s3_pend_end",   pend_cnt,     0);
        check("s3_ovf_sticky", ref_overflow, 1);

        // ---------------- tick coincident with refresh ----------------
        ref_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); ref_int = 1'b1;
        end
        cyc(); ref_int = 1'b0;
        check("s4_pend3", pend_cnt, 3);
        ref_ack = 1'b1;                             // cycle A
        for (int k = 1; k <= 4; k++) cyc();
        check("s4_aref_now", cmd_auto_ref, 1);
        check("s4_pend_pre", pend_cnt,     3);
        ref_int = 1'b1;
        cyc(); ref_int = 1'b0;
        check("s4_pend_same", pend_cnt, 3);
        drain(n_aref, done);
        check("s4_drain_done", done,     1);
        check("s4_n_aref",     n_aref,   3);
        check("s4_pend_end",   pend_cnt, 0);

        // ---------------- reset in WAIT_RP ----------------
        ref_ack = 1'b1;
        cyc(); ref_int = 1'b1;                      // cycle 0
        cyc(); ref_int = 1'b0;                      // cycle 1
        cyc(); cyc(); cyc();                        // cycle 4: WAIT_RP
        check("s5_req_before",  ref_req,  1);
        check("s5_pend_before", pend_cnt, 1);
        reset = 1'b0;
        #1;
        check("s5_req",      ref_req,      0);
        check("s5_pre",      cmd_pre_all,  0);
        check("s5_aref",     cmd_auto_ref, 0);
        check("s5_busy",     ref_busy,     0);
        check("s5_pend",     pend_cnt,     0);
        check("s5_urgent",   urgent,       0);
        check("s5_overflow", ref_overflow, 0);
        cyc(); reset = 1'b1;
        aref_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (cmd_auto_ref || cmd_pre_all || ref_req) aref_seen = 1'b1;
        end
        check("s5_no_strobe", aref_seen, 0);
        check("s5_pend_after", pend_cnt, 0);

        // ---------------- T_RP=1, T_RFC=1 corners ----------------
        ref_ack_c = 1'b1;
        cyc(); ref_int_c = 1'b1;                    // ticks in cycles 0 and 1
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 2) ref_int_c = 1'b0;
            check($sformatf("s6_pre_c%0d", c),  cmd_pre_all_c,  32'(c == 3));
            check($sformatf("s6_aref_c%0d", c), cmd_auto_ref_c, 32'(c == 4 || c == 5));
            check($sformatf("s6_req_c%0d", c),  ref_req_c,      32'(c >= 2 && c <= 5));
            exp_pend = (c == 1) ? 1 : (c <= 4) ? 2 : (c == 5) ? 1 : 0;
            check($sformatf("s6_pend_c%0d", c), pend_cnt_c,     32'(exp_pend));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
